// File: rtl/uart_tx_fifo_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// uart_tx_fifo_if : byte write handshake into the UART transmit FIFO
// Revision: 1.0
// ---------------------------------------------------------------------------
interface uart_tx_fifo_if;
    logic [7:0] wr_data;
    logic       wr_valid;
    logic       wr_ready;

    modport master (output wr_data, output wr_valid, input wr_ready);
    modport slave  (input wr_data, input wr_valid, output wr_ready);
endinterface
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// uart_tx_fifo : buffered 8N1 UART transmitter, FIFO drained by a bit FSM
// Revision: 1.0
// ---------------------------------------------------------------------------
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_AW      = 4
) (
    input  logic               sysclk,
    input  logic               rst,
    uart_tx_fifo_if.slave      wr,
    output logic               uart_tx,
    output logic [FIFO_AW:0]   fifo_count,
    output logic               tx_busy
);
    localparam int DEPTH = 1 << FIFO_AW;
    localparam int CW    = $clog2(CLKS_PER_BIT);
    localparam logic [FIFO_AW:0] FULL_COUNT = (FIFO_AW+1)'(DEPTH);
    localparam logic [CW-1:0]    BAUD_LAST  = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    logic [7:0]         mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
    state_t             state, state_nxt;
    logic [7:0]         shift, shift_nxt;
    logic [2:0]         bit_idx, bit_idx_nxt;
    logic [CW-1:0]      baud, baud_nxt;
    logic               tx_nxt;
    logic               push, pop, fifo_empty, baud_done;

    assign wr.wr_ready = (fifo_count != FULL_COUNT);
    assign push        = wr.wr_valid && wr.wr_ready;
    assign fifo_empty  = (fifo_count == '0);
    assign baud_done   = (baud == BAUD_LAST);
    assign tx_busy     = (state != IDLE) || !fifo_empty;

    always_ff @(posedge sysclk) begin
        if (push) begin
            mem[wr_ptr] <= wr.wr_data;
        end
    end

    always_ff @(posedge sysclk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + FIFO_AW'(1);
            if (pop)  rd_ptr <= rd_ptr + FIFO_AW'(1);
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + (FIFO_AW+1)'(1);
                2'b01:   fifo_count <= fifo_count - (FIFO_AW+1)'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge sysclk) begin
        if (rst) begin
            state   <= IDLE;
            shift   <= '0;
            bit_idx <= '0;
            baud    <= '0;
            uart_tx <= 1'b1;
        end else begin
            state   <= state_nxt;
            shift   <= shift_nxt;
            bit_idx <= bit_idx_nxt;
            baud    <= baud_nxt;
            uart_tx <= tx_nxt;
        end
    end

    // The line level is derived from the next state so uart_tx stays registered
    // yet changes on the same edge that enters each bit.
    always_comb begin
        state_nxt   = state;
        shift_nxt   = shift;
        bit_idx_nxt = bit_idx;
        baud_nxt    = baud;
        pop         = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    shift_nxt = mem[rd_ptr];
                    baud_nxt  = '0;
                    state_nxt = START;
                end
            end
            START: begin
                if (baud_done) begin
                    baud_nxt    = '0;
                    bit_idx_nxt = '0;
                    state_nxt   = DATA;
                end else begin
                    baud_nxt = baud + CW'(1);
                end
            end
            DATA: begin
                if (baud_done) begin
                    baud_nxt    = '0;
                    shift_nxt   = shift >> 1;
                    bit_idx_nxt = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) state_nxt = STOP;
                end else begin
                    baud_nxt = baud + CW'(1);
                end
            end
            STOP: begin
                if (baud_done) begin
                    baud_nxt = '0;
                    if (!fifo_empty) begin
                        pop       = 1'b1;
                        shift_nxt = mem[rd_ptr];
                        state_nxt = START;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else begin
                    baud_nxt = baud + CW'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase

        tx_nxt = 1'b1;
        case (state_nxt)
            START:   tx_nxt = 1'b0;
            DATA:    tx_nxt = shift_nxt[0];
            default: tx_nxt = 1'b1;
        endcase
    end
endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_uart_tx_fifo : scoreboard bench, line decoder checks bytes against queue
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_uart_tx_fifo;
    localparam int CPB   = 4;
    localparam int AW    = 4;
    localparam int FRAME = 10 * CPB;

    logic          sysclk = 1'b0;
    logic          rst    = 1'b1;
    logic          uart_tx;
    logic          tx_busy;
    logic [AW:0]   fifo_count;

    uart_tx_fifo_if wr_if();

    uart_tx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_AW(AW)) dut (
        .sysclk     (sysclk),
        .rst        (rst),
        .wr         (wr_if),
        .uart_tx    (uart_tx),
        .fifo_count (fifo_count),
        .tx_busy    (tx_busy)
    );

    always #5 sysclk = ~sysclk;

    int cyc = 0;
    always @(posedge sysclk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;
    logic [7:0] exp_q[$];
    int gaps_q[$];
    int frames_done = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Scoreboard push: a byte is accepted at the coming edge when valid && ready.
    always @(negedge sysclk) begin
        if (!rst && wr_if.wr_valid && wr_if.wr_ready) exp_q.push_back(wr_if.wr_data);
    end

    // Line decoder: one sample per cycle, CPB samples per bit, 10 bits per frame.
    int         mon_cnt  = -1;
    int         prev_end = -1;
    int         glitches = 0;
    logic [9:0] bits;
    always @(negedge sysclk) begin
        if (rst) begin
            mon_cnt  = -1;
            prev_end = -1;
            exp_q.delete();
        end else if (mon_cnt < 0) begin
            if (uart_tx === 1'b0) begin
                if (prev_end >= 0) gaps_q.push_back(cyc - prev_end - 1);
                bits[0]  = 1'b0;
                glitches = 0;
                mon_cnt  = 1;
            end
        end else begin
            if (mon_cnt % CPB == 0) bits[mon_cnt / CPB] = uart_tx;
            else if (uart_tx !== bits[mon_cnt / CPB]) glitches++;
            if (mon_cnt == FRAME - 1) begin
                check("bit_stable", glitches, 0);
                check("stop_bit", {31'd0, bits[9]}, 1);
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL rx_spurious: got byte %0h expected none", bits[8:1]);
                end else begin
                    check("rx_byte", {24'd0, bits[8:1]}, {24'd0, exp_q.pop_front()});
                end
                frames_done++;
                prev_end = cyc;
                mon_cnt  = -1;
            end else begin
                mon_cnt++;
            end
        end
    end

    task automatic sync();
        @(posedge sysclk);
        #1;
    endtask

    task automatic send(input logic [7:0] b, output int acc_cyc);
        bit acc;
        acc = 1'b0;
        wr_if.wr_data  = b;
        wr_if.wr_valid = 1'b1;
        for (int i = 0; i < 200 && !acc; i++) begin
            @(negedge sysclk);
            acc = wr_if.wr_ready && !rst;
            @(posedge sysclk);
            #1;
        end
        acc_cyc = cyc;
        if (!acc) begin
            total++;
            bad++;
            $display("FAIL send_timeout: got no accept expected accept of %0h", b);
        end
        wr_if.wr_valid = 1'b0;
    endtask

    task automatic wait_idle(input int limit, output int idle_cyc);
        int n;
        n = 0;
        do begin
            @(negedge sysclk);
            n++;
        end while (tx_busy !== 1'b0 && n < limit);
        idle_cyc = cyc;
        check("drain_busy", {31'd0, tx_busy}, 0);
        sync();
    endtask

    initial begin
        int k, k1, f0, idle_cyc, idle_bad, gsum;
        wr_if.wr_valid = 1'b0;
        wr_if.wr_data  = 8'h00;
        rst = 1'b1;
        repeat (3) @(posedge sysclk);
        #1 rst = 1'b0;

        @(negedge sysclk);
        check("rst_tx", {31'd0, uart_tx}, 1);
        check("rst_ready", {31'd0, wr_if.wr_ready}, 1);
        check("rst_count", {27'd0, fifo_count}, 0);
        check("rst_busy", {31'd0, tx_busy}, 0);

        idle_bad = 0;
        repeat (1000) begin
            @(negedge sysclk);
            if (uart_tx !== 1'b1 || tx_busy !== 1'b0) idle_bad++;
        end
        check("idle_line", idle_bad, 0);

        // Single byte: latency and frame length
        sync();
        f0 = frames_done;
        send(8'hA5, k);
        check("pre_pop_tx", {31'd0, uart_tx}, 1);
        check("count_after_push", {27'd0, fifo_count}, 1);
        sync();
        check("start_latency", {31'd0, uart_tx}, 0);
        check("count_after_pop", {27'd0, fifo_count}, 0);
        check("busy_in_frame", {31'd0, tx_busy}, 1);
        wait_idle(500, idle_cyc);
        check("single_busy_len", idle_cyc - k, FRAME + 1);
        check("single_frames", frames_done - f0, 1);
        check("single_count", {27'd0, fifo_count}, 0);
        check("single_sb_empty", exp_q.size(), 0);

        // Back-to-back burst
        gaps_q.delete();
        f0 = frames_done;
        send(8'h00, k);
        send(8'hFF, k);
        send(8'h55, k);
        wait_idle(1000, idle_cyc);
        check("burst_frames", frames_done - f0, 3);
        check("burst_gap_n", gaps_q.size(), 3);
        if (gaps_q.size() >= 3) begin
            check("burst_gap1", gaps_q[1], 0);
            check("burst_gap2", gaps_q[2], 0);
        end

        // Full FIFO: 17 accepted, 18th stalls until the next pop
        gaps_q.delete();
        f0 = frames_done;
        send(8'h01, k1);
        for (int b = 2; b <= 17; b++) send(8'(b), k);
        check("full_accept_cycle", k - k1, 16);
        check("full_count", {27'd0, fifo_count}, 16);
        check("full_ready", {31'd0, wr_if.wr_ready}, 0);
        send(8'h12, k);
        check("stall_release", k - k1, FRAME + 2);
        wait_idle(3000, idle_cyc);
        check("full_frames", frames_done - f0, 18);
        gsum = 0;
        for (int i = 1; i < gaps_q.size(); i++) gsum += gaps_q[i];
        check("full_no_gap", gsum, 0);
        check("full_sb_empty", exp_q.size(), 0);

        // Pointer wrap: incrementing stream with random pauses, then random data
        f0 = frames_done;
        for (int i = 0; i < 40; i++) begin
            send(8'(8'h20 + i), k);
            repeat ($urandom_range(0, 2)) sync();
        end
        for (int i = 0; i < 24; i++) begin
            send(8'($urandom), k);
            repeat ($urandom_range(0, 3)) sync();
        end
        wait_idle(5000, idle_cyc);
        check("wrap_frames", frames_done - f0, 64);
        check("wrap_sb_empty", exp_q.size(), 0);

        // Reset during data bit 3 with 5 bytes queued
        send(8'hC3, k1);
        for (int i = 0; i < 5; i++) send(8'(8'h70 + i), k);
        check("pre_rst_count", {27'd0, fifo_count}, 5);
        while (cyc < k1 + 18) sync();
        rst = 1'b1;
        sync();
        rst = 1'b0;
        check("mid_rst_tx", {31'd0, uart_tx}, 1);
        check("mid_rst_count", {27'd0, fifo_count}, 0);
        check("mid_rst_busy", {31'd0, tx_busy}, 0);
        check("mid_rst_ready", {31'd0, wr_if.wr_ready}, 1);
        f0 = frames_done;
        send(8'h3C, k);
        wait_idle(500, idle_cyc);
        check("post_rst_frames", frames_done - f0, 1);
        check("post_rst_sb_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Buffered 8N1 UART transmitter that drives the board-level `uart_tx` pin of `neocpu`. The CPU core's memory-mapped output store writes bytes into a small FIFO through a valid/ready handshake, and a bit-serial FSM drains that FIFO onto the line at a fixed baud rate. The block decouples CPU store timing from the slow serial line. It also exposes occupancy and busy status so firmware can poll before halting.

## Interface
- `CLKS_PER_BIT`, default 868: `sysclk` cycles per serial bit (100 MHz / 115200). Must be ≥ 2.
- `FIFO_AW`, default 4: FIFO address width; depth = 2^FIFO_AW = 16 entries.

- `sysclk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  reset, synchronous, active-high (top level drives it from `~cpu_resetn`).
- `wr_data`  in  8  byte to transmit.
- `wr_valid`  in  1  `wr_data` is valid this cycle.
- `wr_ready`  out  1  FIFO can accept a byte (= not full).
- `uart_tx`  out  1  serial line, registered, idle high.
- `fifo_count`  out  FIFO_AW+1  bytes currently queued (0..16).
- `tx_busy`  out  1  frame in progress or FIFO non-empty.

## Operation
- Push occurs when `wr_valid && wr_ready` at a rising edge. Byte is ignored when `wr_ready`=0 (no overwrite).
- FIFO is a circular buffer with FIFO_AW-bit read/write pointers that wrap modulo depth. `fifo_count` counts up on push, down on pop, and is unchanged on simultaneous push+pop.
- `wr_ready` = (`fifo_count` != 2^FIFO_AW), combinational from registered count.
- FSM states and transitions:
  - IDLE: `uart_tx`=1. If FIFO is non-empty, pop the head into the shift register, clear the baud counter, go to START.
  - START: `uart_tx`=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: `uart_tx`=shift[0], LSB first. After CLKS_PER_BIT cycles, shift right and increment bit index. After bit 7 completes, go to STOP.
  - STOP: `uart_tx`=1 for CLKS_PER_BIT cycles. On the last cycle, if the FIFO is non-empty, pop and go directly to START (no idle gap); otherwise go to IDLE.
- The baud counter runs 0..CLKS_PER_BIT-1 and is reset on every bit boundary. Its width is clog2(CLKS_PER_BIT).
- `tx_busy` = (state != IDLE) || (`fifo_count` != 0).
- Push into a full FIFO while a pop is occurring the same cycle is not accepted, because `wr_ready` is already 0. `wr_ready` rises the cycle after the pop.

## Timing
- Reset values: `uart_tx`=1, `wr_ready`=1, `fifo_count`=0, `tx_busy`=0, state=IDLE, pointers=0, baud counter=0.
- Reset mid-frame aborts the frame and discards all queued bytes. `uart_tx` is high after the reset edge.
- Latency: a byte accepted at edge k into an empty FIFO with FSM in IDLE is popped at edge k+1, and `uart_tx` is low after edge k+1.
- Frame length is exactly 10×CLKS_PER_BIT cycles. Back-to-back frames have no gap.
- Push into an empty FIFO on the same edge the FSM is in IDLE: the byte is not visible to the FSM until the next edge. There is no bypass path.
- `fifo_count` decrements on the pop edge (k+1 above). `tx_busy` stays high until the final stop-bit cycle completes with an empty FIFO.

## Test plan
Run all scenarios with `CLKS_PER_BIT`=4 and a bit-period line monitor.
- Single byte: write 0xA5 once. `uart_tx` low 1 edge after accept, then line sequence 0,1,0,1,0,0,1,0,1,1 (start, LSB-first data, stop), each bit 4 cycles, 40 cycles total. Afterwards `tx_busy`=0 and `fifo_count`=0.
- Burst/back-to-back: write 0x00, 0xFF, 0x55 on consecutive cycles. Expect 3 frames of 40 cycles each with no idle cycle between the stop bit and the next start bit. Decoded bytes match in order.
- Full FIFO: write 17 bytes 0x01..0x11 with `wr_valid` held high. `wr_ready` drops when `fifo_count` reaches 16, with one byte already popped into the FSM, so 17 are accepted. Further writes are stalled, and `wr_ready` returns high the cycle after the next pop. All accepted bytes are transmitted in order, none dropped or duplicated.
- Pointer wrap: stream 40 bytes (incrementing values) with writer throttled on `wr_ready`. Received data equals sent data across multiple pointer wrap-arounds.
- Reset mid-frame: assert `rst` during DATA bit 3 with 5 bytes queued. After the reset edge, `uart_tx`=1, `fifo_count`=0, `tx_busy`=0, `wr_ready`=1. A subsequent single write transmits correctly.
- Idle line: no writes for 1000 cycles after reset. `uart_tx` is constant 1 and `tx_busy` is constant 0.
